hough_accum_vote: RTL

- Consumer end of the rho FIFO filled by the rho-calculation stage. The producer writes one rho bin index per (pixel, theta), in theta order 0..THETAS-1.
- This block pops each rho, pairs it with an internal theta counter that runs in lockstep with the producer, and votes. A vote is a read-modify-write increment of bin theta*RHOS+rho in an internal accumulator RAM.
- After the frame it streams every bin count, in address order, into an output FIFO for peak detection.

---
 rtl/hough_pkg.sv | 26 ++
 rtl/hough_accum_bram.sv | 27 ++
 rtl/hough_accum_vote.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hough_pkg.sv
// Shared Hough-transform constants, accumulator FSM states and a saturating increment.
// Latency: n/a (package only).
// Backpressure: n/a.
package hough_pkg;

  localparam int THETAS    = 180;
  localparam int RHOS      = 800;
  localparam int RHO_BITS  = 10;
  localparam int ACC_BITS  = 16;
  localparam int ADDR_BITS = 18;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FLUSH,
    READOUT,
    DONE
  } state_e;

  // Increment that sticks at max_val; callers zero-extend their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hough_accum_bram.sv
// Simple dual-port accumulator RAM: one write port, one synchronous read port.
// Latency: read data 1 cycle after address; read-during-write returns old data.
// Backpressure: none, both ports accept every cycle.
// Ports: clock; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out.
module hough_accum_bram #(
  parameter int ADDR_BITS = 18,
  parameter int ACC_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [ACC_BITS-1:0]  wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [ACC_BITS-1:0]  rd_data
);

  logic [ACC_BITS-1:0] mem [2**ADDR_BITS];
  logic [ACC_BITS-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hough_accum_vote.sv
// Hough vote accumulator: clears the bin RAM, votes one rho word per cycle, streams all bins out.
// Latency: pop to RAM write 2 cycles; readout push 1 cycle after each RAM read.
// Backpressure: pops only when rho FIFO non-empty; acc_full stalls readout via a one-entry skid.
// Ports: clock/reset; start, frame_done control; rho_* FIFO read side; acc_* FIFO write side;
//        busy (not IDLE/DONE), done (one-cycle pulse after the last bin is pushed).
module hough_accum_vote #(
  parameter int THETAS    = hough_pkg::THETAS,
  parameter int RHOS      = hough_pkg::RHOS,
  parameter int RHO_BITS  = hough_pkg::RHO_BITS,
  parameter int ACC_BITS  = hough_pkg::ACC_BITS,
  parameter int ADDR_BITS = hough_pkg::ADDR_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                frame_done,
  input  logic [RHO_BITS-1:0] rho_dout,
  input  logic                rho_empty,
  output logic                rho_rd_en,
  output logic [ACC_BITS-1:0] acc_din,
  input  logic                acc_full,
  output logic                acc_wr_en,
  output logic                busy,
  output logic                done
);
  import hough_pkg::*;

  localparam int CW      = ADDR_BITS + 1;
  localparam int RW      = RHO_BITS + 1;
  localparam int TH_BITS = $clog2(THETAS + 1);
  localparam logic [CW-1:0]        CNT_LAST   = CW'(THETAS * RHOS - 1);
  localparam logic [CW-1:0]        CNT_END    = CW'(THETAS * RHOS);
  localparam logic [ADDR_BITS-1:0] RHO_STEP   = ADDR_BITS'(RHOS);
  localparam logic [RW-1:0]        RHO_LIM    = RW'(RHOS);
  localparam logic [TH_BITS-1:0]   THETA_LAST = TH_BITS'(THETAS - 1);
  localparam logic [ACC_BITS-1:0]  ACC_MAX    = '1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;          // clear address, then readout address
  logic [TH_BITS-1:0]   theta_q, theta_d;
  logic [ADDR_BITS-1:0] base_q, base_d;        // theta_q * RHOS, kept as a running sum
  logic                 fd_q, fd_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [ADDR_BITS-1:0] s1_addr_q, s1_addr_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [ADDR_BITS-1:0] s2_addr_q, s2_addr_d;
  logic                 fwd_vld_q, fwd_vld_d;
  logic [ACC_BITS-1:0]  fwd_dat_q, fwd_dat_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [ACC_BITS-1:0]  skid_dat_q, skid_dat_d;
  logic                 done_q, done_d;

  logic                 pop, issue;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_wa, ram_ra;
  logic [ACC_BITS-1:0]  ram_wd, ram_rd_data;
  logic [ACC_BITS-1:0]  old_cnt, vote_dat;
  logic                 cand_vld;
  logic [ACC_BITS-1:0]  cand_dat;

  hough_accum_bram #(.ADDR_BITS(ADDR_BITS), .ACC_BITS(ACC_BITS)) u_bram (
    .clock   (clock),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd),
    .rd_addr (ram_ra),
    .rd_data (ram_rd_data)
  );

  // The RAM read in S1 misses the S2 write landing on the same edge, so that
  // value is carried forward one cycle and replaces the stale read data.
  assign old_cnt  = fwd_vld_q ? fwd_dat_q : ram_rd_data;
  assign vote_dat = ACC_BITS'(sat_inc(32'(old_cnt), 32'(ACC_MAX)));

  // Readout candidate: a stalled word in the skid wins over fresh RAM data.
  // Reads are only issued when the previous word leaves, so both never coexist.
  assign cand_vld = skid_vld_q || rd_pend_q;
  assign cand_dat = skid_vld_q ? skid_dat_q : ram_rd_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    theta_d    = theta_q;
    base_d     = base_q;
    fd_d       = fd_q || frame_done;
    s1_vld_d   = 1'b0;
    s1_addr_d  = s1_addr_q;
    s2_vld_d   = s1_vld_q;
    s2_addr_d  = s1_addr_q;
    fwd_vld_d  = s2_vld_q && s1_vld_q && (s2_addr_q == s1_addr_q);
    fwd_dat_d  = vote_dat;
    rd_pend_d  = 1'b0;
    skid_vld_d = cand_vld && acc_full;
    skid_dat_d = cand_dat;
    done_d     = 1'b0;
    pop        = 1'b0;
    issue      = 1'b0;
    ram_we     = 1'b0;
    ram_wa     = s2_addr_q;
    ram_wd     = vote_dat;
    ram_ra     = s1_addr_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fd_d    = 1'b0;
          theta_d = '0;
          base_d  = '0;
        end
      end
      CLEAR: begin
        ram_we = 1'b1;
        ram_wa = cnt_q[ADDR_BITS-1:0];
        ram_wd = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        pop    = !rho_empty;
        ram_we = s2_vld_q;
        if (pop) begin
          // Out-of-range words still consume a theta slot to keep alignment.
          s1_vld_d  = ({1'b0, rho_dout} < RHO_LIM);
          s1_addr_d = base_q + ADDR_BITS'(rho_dout);
          if (theta_q == THETA_LAST) begin
            theta_d = '0;
            base_d  = '0;
          end else begin
            theta_d = theta_q + 1'b1;
            base_d  = base_q + RHO_STEP;
          end
        end
        if (fd_q && rho_empty) state_d = FLUSH;
      end
      FLUSH: begin
        ram_we = s2_vld_q;
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = READOUT;
          cnt_d   = '0;
          theta_d = '0;
          base_d  = '0;
        end
      end
      READOUT: begin
        ram_ra = cnt_q[ADDR_BITS-1:0];
        issue  = (cnt_q != CNT_END) && (!cand_vld || !acc_full);
        if (issue) begin
          cnt_d     = cnt_q + 1'b1;
          rd_pend_d = 1'b1;
        end
        if (acc_wr_en && (cnt_q == CNT_END)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      theta_q    <= '0;
      base_q     <= '0;
      fd_q       <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_addr_q  <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_dat_q  <= '0;
      rd_pend_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      theta_q    <= theta_d;
      base_q     <= base_d;
      fd_q       <= fd_d;
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s2_vld_q   <= s2_vld_d;
      s2_addr_q  <= s2_addr_d;
      fwd_vld_q  <= fwd_vld_d;
      fwd_dat_q  <= fwd_dat_d;
      rd_pend_q  <= rd_pend_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      done_q     <= done_d;
    end
  end

  assign rho_rd_en = pop;
  assign acc_wr_en = cand_vld && !acc_full;
  assign acc_din   = cand_vld ? cand_dat : '0;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = done_q;

endmodule
